// File: rtl/c10_tape_pkg.sv
// c10_tape_pkg: shared types and helpers for the C10 cassette player.
// Holds the state enum, the half-period calculation and the bit positions used in status.
package c10_tape_pkg;

    typedef enum logic [2:0] {
        STOP,
        FETCH,
        WAIT,
        BIT,
        PAUSE,
        LEADER
    } state_t;

    // Bit positions inside status = {eot, paused, playing}
    localparam int ST_PLAYING = 0;
    localparam int ST_PAUSED  = 1;
    localparam int ST_EOT     = 2;

    // Byte value used for the synthetic leader
    localparam logic [7:0] LEAD_BYTE = 8'h55;

    // One tone cycle is high for half a period, then low for half a period.
    // Integer division is intentional; any rounding stays fixed at elaboration time.
    function automatic int half_period(input int clk_hz, input int tone_hz);
        return clk_hz / (2 * tone_hz);
    endfunction

endpackage

// File: rtl/fsk_bit_gen.sv
// fsk_bit_gen: emits one FSK bit cycle.
// The output is high for hp cycles, then low for hp cycles (hp = hp1 or hp0).
// done pulses in the final low cycle, so a start in that same cycle runs bits back-to-back.
// abort kills a bit in flight and forces the output low on the next cycle.
module fsk_bit_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             start,
    input  logic             bit_val,
    input  logic [CNT_W-1:0] hp1,
    input  logic [CNT_W-1:0] hp0,
    output logic             tape_out,
    output logic             done
);

    logic             busy;
    logic             low_half;
    logic [CNT_W-1:0] hp;
    logic [CNT_W-1:0] cnt;
    logic             last_cyc;

    assign last_cyc = (cnt == hp - CNT_W'(1));
    assign done     = busy && low_half && last_cyc;

    // Half-period counter: a start (re)loads it, otherwise it walks high half then low half
    always_ff @(posedge clk) begin
        if (reset || abort) begin
            busy     <= 1'b0;
            low_half <= 1'b0;
            hp       <= '0;
            cnt      <= '0;
            tape_out <= 1'b0;
        end else if (start) begin
            busy     <= 1'b1;
            low_half <= 1'b0;
            hp       <= bit_val ? hp1 : hp0;
            cnt      <= '0;
            tape_out <= 1'b1;
        end else if (busy) begin
            if (last_cyc) begin
                cnt <= '0;
                if (!low_half) begin
                    low_half <= 1'b1;
                    tape_out <= 1'b0;
                end else begin
                    busy <= 1'b0;
                end
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/c10_tape_player.sv
// c10_tape_player: reads a C10 image from SDRAM and plays it back as MC-10/Alice FSK.
// A 1 bit is one 2400 Hz cycle and a 0 bit is one 1200 Hz cycle. Each byte goes out LSB first.
// Optional feature: define TAPE_LEADER_EN to send LEADER_BYTES bytes of 0x55 before a play that starts at address 0.
module c10_tape_player
    import c10_tape_pkg::*;
#(
    parameter int CLK_HZ       = 50_000_000,
    parameter int ADDR_W       = 25,
    parameter int READ_LAT     = 4,
    parameter int LEADER_BYTES = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              play,
    input  logic              rewind,
    input  logic [ADDR_W-1:0] file_size,
    input  logic              loaded,
    output logic [ADDR_W-1:0] sdram_addr,
    output logic              sdram_rd,
    input  logic [7:0]        sdram_data,
    output logic              tape_out,
    output logic [2:0]        status,
    output logic [7:0]        cur_byte
);

    localparam int HP1   = half_period(CLK_HZ, 2400);
    localparam int HP0   = half_period(CLK_HZ, 1200);
    localparam int CNT_W = $clog2(HP0 + 1);
    localparam int LC_W  = $clog2(LEADER_BYTES + 1);
`ifdef TAPE_LEADER_EN
    localparam int LEAD_N = LEADER_BYTES;
`else
    localparam int LEAD_N = 0;
`endif
    localparam logic [CNT_W-1:0] HP1_C = CNT_W'(HP1);
    localparam logic [CNT_W-1:0] HP0_C = CNT_W'(HP0);

    // edge detectors
    logic play_q, rew_q, ld_q;
    logic play_e, ld_e, abort;
    logic [ADDR_W-1:0] size_q;

    // read-latency tracker: vld_pipe[k] means a read was issued k cycles ago
    logic [READ_LAT:1] vld_q;
    logic [READ_LAT:0] vld_pipe;

    // state registers and their next values
    state_t            state, state_d, rs, rs_d, nxt_st;
    logic [ADDR_W-1:0] addr_d;
    logic [7:0]        shreg, shreg_d, cur_d;
    logic [2:0]        idx, idx_d, nxt_idx;
    logic              eot, eot_d, paused, paused_d, playing, playing_d;
    logic              pend, pend_d, pend_n, spend, spend_d;
    logic [LC_W-1:0]   lcnt, lcnt_d, nxt_lcnt;
    logic              nxt_go, nxt_eot;
    logic              bit_start, bit_val, bit_done;

    assign play_e   = play & ~play_q;
    assign ld_e     = loaded & ~ld_q;
    // A rewind edge, a fresh load, or no image at all puts the player back at address 0.
    assign abort    = (rewind & ~rew_q) | ld_e | ~loaded;
    assign vld_pipe = {vld_q, sdram_rd};

    assign status[ST_EOT]     = eot;
    assign status[ST_PAUSED]  = paused;
    assign status[ST_PLAYING] = playing;

    // Edge-detect flops, image size latch and read-latency shift register
    always_ff @(posedge clk) begin
        if (reset) begin
            play_q <= 1'b0;
            rew_q  <= 1'b0;
            ld_q   <= 1'b0;
            size_q <= '0;
            vld_q  <= '0;
        end else begin
            play_q <= play;
            rew_q  <= rewind;
            ld_q   <= loaded;
            if (ld_e) size_q <= file_size;
            // Reads in flight when the player aborts are dropped here.
            vld_q  <= abort ? '0 : vld_pipe[READ_LAT-1:0];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= STOP;
            rs         <= STOP;
            sdram_addr <= '0;
            shreg      <= '0;
            cur_byte   <= '0;
            idx        <= '0;
            eot        <= 1'b0;
            paused     <= 1'b0;
            playing    <= 1'b0;
            pend       <= 1'b0;
            spend      <= 1'b0;
            lcnt       <= '0;
        end else begin
            state      <= state_d;
            rs         <= rs_d;
            sdram_addr <= addr_d;
            shreg      <= shreg_d;
            cur_byte   <= cur_d;
            idx        <= idx_d;
            eot        <= eot_d;
            paused     <= paused_d;
            playing    <= playing_d;
            pend       <= pend_d;
            spend      <= spend_d;
            lcnt       <= lcnt_d;
        end
    end

    // Next-state logic: playback sequencing, pause handling and addressing
    always_comb begin
        state_d   = state;
        rs_d      = rs;
        addr_d    = sdram_addr;
        shreg_d   = shreg;
        cur_d     = cur_byte;
        idx_d     = idx;
        eot_d     = eot;
        paused_d  = paused;
        playing_d = playing;
        pend_d    = pend;
        spend_d   = 1'b0;
        lcnt_d    = lcnt;
        sdram_rd  = 1'b0;
        bit_start = 1'b0;
        bit_val   = 1'b0;
        nxt_st    = state;
        nxt_idx   = idx + 3'd1;
        nxt_lcnt  = lcnt;
        nxt_go    = 1'b1;
        nxt_eot   = 1'b0;
        pend_n    = pend ^ play_e;

        if (abort) begin
            state_d   = STOP;
            addr_d    = '0;
            eot_d     = 1'b0;
            paused_d  = 1'b0;
            playing_d = 1'b0;
            pend_d    = 1'b0;
        end else begin
            unique case (state)
                STOP: begin
                    if (play_e) begin
                        if (sdram_addr < size_q) begin
                            playing_d = 1'b1;
                            eot_d     = 1'b0;
                            if (LEAD_N > 0 && sdram_addr == '0) begin
                                state_d = LEADER;
                                shreg_d = LEAD_BYTE;
                                cur_d   = LEAD_BYTE;
                                idx_d   = '0;
                                lcnt_d  = '0;
                                spend_d = 1'b1;
                            end else begin
                                state_d = FETCH;
                            end
                        end else begin
                            eot_d = 1'b1;
                        end
                    end
                end
                FETCH: begin
                    sdram_rd = 1'b1;
                    pend_d   = pend_n;
                    state_d  = WAIT;
                end
                WAIT: begin
                    pend_d = pend_n;
                    if (vld_pipe[READ_LAT]) begin
                        shreg_d = sdram_data;
                        cur_d   = sdram_data;
                        idx_d   = '0;
                        addr_d  = (sdram_addr < size_q) ? sdram_addr + ADDR_W'(1) : sdram_addr;
                        spend_d = 1'b1;
                        state_d = BIT;
                    end
                end
                BIT, LEADER: begin
                    pend_d = pend_n;
                    if (spend) begin
                        // first bit after a fresh byte or a resume
                        bit_start = 1'b1;
                        bit_val   = shreg[idx];
                    end else if (bit_done) begin
                        if (idx == 3'd7) begin
                            nxt_idx = '0;
                            if (state == LEADER && int'(lcnt) < LEAD_N - 1) begin
                                nxt_lcnt = lcnt + LC_W'(1);
                            end else if (sdram_addr < size_q) begin
                                nxt_st = FETCH;
                                nxt_go = 1'b0;
                            end else begin
                                nxt_eot = 1'b1;
                            end
                        end
                        if (nxt_eot) begin
                            state_d   = STOP;
                            eot_d     = 1'b1;
                            playing_d = 1'b0;
                            pend_d    = 1'b0;
                        end else if (pend_n) begin
                            // Record where to pick up; a resume starts the next bit or the next byte.
                            state_d   = PAUSE;
                            rs_d      = nxt_st;
                            idx_d     = nxt_idx;
                            lcnt_d    = nxt_lcnt;
                            paused_d  = 1'b1;
                            playing_d = 1'b0;
                            pend_d    = 1'b0;
                        end else begin
                            state_d   = nxt_st;
                            idx_d     = nxt_idx;
                            lcnt_d    = nxt_lcnt;
                            bit_start = nxt_go;
                            bit_val   = shreg[nxt_idx];
                        end
                    end
                end
                PAUSE: begin
                    if (play_e) begin
                        state_d   = rs;
                        paused_d  = 1'b0;
                        playing_d = 1'b1;
                        spend_d   = (rs != FETCH);
                    end
                end
                default: state_d = STOP;
            endcase
        end
    end

    fsk_bit_gen #(.CNT_W(CNT_W)) u_bit (
        .clk      (clk),
        .reset    (reset),
        .abort    (abort),
        .start    (bit_start),
        .bit_val  (bit_val),
        .hp1      (HP1_C),
        .hp0      (HP0_C),
        .tape_out (tape_out),
        .done     (bit_done)
    );

endmodule
